rf_wport_arb: RTL and testbench
===============================

Name: rf_wport_arb

Overview:
Arbiter for the single register-file write port. It shares the port between the in-order WB stage writeback and a long-latency unit (mul/div, multi-cycle results) that completes out of band. WB always has priority. Long-latency results wait in a small FIFO and drain on cycles where WB does not write. A starvation counter requests a one-cycle WB bubble, and pending-write hit outputs let ID stall on RAW hazards against queued results.

Parameters:
DEPTH, 2, long-latency result FIFO entries; power of 2, at least 2
STARVE_MAX, 4, consecutive blocked cycles of a non-empty FIFO before wb_hold is raised

Ports:
clk  in  1  clock; all state updates on posedge
resetn  in  1  asynchronous active-low reset
wb_to_rf_data  in  38  WB write bundle {we[37], waddr[36:32], wdata[31:0]}
lu_valid  in  1  long-latency result valid
lu_ready  out  1  FIFO can accept
lu_waddr  in  5  long-latency destination register
lu_wdata  in  32  long-latency result data
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
wb_hold  out  1  registered; upstream must insert a WB bubble
id_raddr1  in  5  ID read address 1
id_raddr2  in  5  ID read address 2
pend_hit1  out  1  id_raddr1 matches a queued write
pend_hit2  out  1  id_raddr2 matches a queued write

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on resetn.
- Reset, asynchronous on resetn low:
  - count, rd_ptr, wr_ptr, starve_cnt and wb_hold clear to 0.
  - Outputs while reset is held: lu_ready=1, rf_we=0, pend_hit1=0, pend_hit2=0.
  - A reset mid-operation discards all queued entries.
- wb_act = we & (waddr != 0). WB writes to x0 never use the port.
- Grant, combinational, same cycle:
  - If wb_act, the port carries the WB bundle.
  - Else if count > 0, the port carries the FIFO head and the head is popped at the edge.
  - Else rf_we=0.
- Enqueue:
  - lu_ready = (count < DEPTH). It does not depend on a same-cycle pop.
  - An entry is written when lu_valid & lu_ready.
  - lu_waddr == 0 completes the handshake but is dropped, not enqueued.
  - A newly enqueued entry is grantable the following cycle at the earliest; there is no bypass.
- Push and pop in the same cycle are legal. count is unchanged and FIFO order is preserved.
- Pointers wrap modulo DEPTH.
- starve_cnt:
  - Clears on a pop or when count == 0.
  - Otherwise increments while count > 0, saturating at STARVE_MAX.
- wb_hold:
  - Registered, equal to (starve_cnt == STARVE_MAX).
  - It is 1 the cycle after the counter saturates and stays 1 until the cycle after the head pops.
  - Contract: while wb_hold=1, the pipeline gates mem_to_wb_valid so WB holds no valid write from the next cycle. The head therefore drains within 2 cycles.
- pend_hitN = (id_raddrN != 0) & (id_raddrN matches the waddr of any valid FIFO entry).
  - This includes the entry being popped this cycle (conservative).
  - ID must not issue a new writer of a pending register. Results in the FIFO are never reordered against WB writes to the same register.
- Illegal condition, flagged by a bench assertion: wb_act while the WB waddr equals a valid FIFO entry waddr.
- rf_* outputs are combinational from the WB input and the FIFO head, so they add zero latency to WB writeback.

Decomposition:
- Shared header holds the bundle widths and field offsets: WB_RF_BUS_WD=38, WE_BIT=37, WADDR_MSB/LSB, WDATA_MSB/LSB. ID, WB and this block use the same definitions.
- The FIFO storage, pointers and count form a natural sub-module, sync_fifo, parameterised by WIDTH=37 and DEPTH, with async active-low reset. It exposes its entry array, or entry-valid mask plus addresses, for the pend_hit compare.
- Grant logic, starvation logic and hit logic stay in rf_wport_arb.

Test Plan:
1. WB idle; lu_valid with addr 5, data 0xDEADBEEF at cycle 0 -> lu_ready=1; cycle 1 has rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; count returns to 0.
2. WB writes x0 (we=1, waddr=0) every cycle; lu sends addr 3 -> entry drains the next cycle with rf_waddr=3; the x0 write never appears on rf_we.
3. WB writes addr 1 every cycle; lu enqueues addr 8 at cycle 0 and addr 9 at cycle 1:
   - lu_ready=0 from cycle 2.
   - wb_hold=1 at cycle 5.
   - Bench drops WB writes from cycle 6; rf_waddr=8 at cycle 6 and 9 at cycle 7.
   - wb_hold=0 from cycle 7.
4. Entry addr 7 queued, id_raddr1=7, id_raddr2=0 -> pend_hit1=1, pend_hit2=0; after the pop cycle, pend_hit1=0.
5. count=1 (addr 4 queued), WB idle, lu pushes addr 9 in the same cycle -> addr 4 is written, count stays 1, and the next cycle writes addr 9.
6. count=2 and wb_hold=1; resetn is pulled low between edges -> lu_ready=1, wb_hold=0, rf_we=0 immediately; after release, no stale entry is written.

Source files
------------

// File: rtl/rf_wport_arb_pkg.sv
// rf_wport_arb_pkg: shared WB write-bundle layout and long-latency entry format
package rf_wport_arb_pkg;
  localparam int WB_RF_BUS_WD = 38;
  localparam int WE_BIT       = 37;
  localparam int WADDR_MSB    = 36;
  localparam int WADDR_LSB    = 32;
  localparam int WDATA_MSB    = 31;
  localparam int WDATA_LSB    = 0;
  localparam int LU_ENT_WD    = 37;
  localparam int RADDR_WD     = 5;
  typedef struct packed {
    logic [RADDR_WD-1:0] waddr;
    logic [31:0]         wdata;
  } lu_ent_t;
endpackage

// File: rtl/rf_wport_arb_sync_fifo.sv
// sync_fifo: small circular FIFO exposing per-entry valid mask and top-bit tags
module sync_fifo
  import rf_wport_arb_pkg::*;
#(
  parameter int WIDTH = LU_ENT_WD,
  parameter int DEPTH = 2,
  parameter int TAG_W = RADDR_WD
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         vld,
  output logic [DEPTH*TAG_W-1:0]   tags
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  // storage needs no reset: the valid mask hides stale slots
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end
  // pointers and occupancy; caller never pushes when full or pops when empty
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_q + AW'(pop);
      wr_q  <= wr_q + AW'(push);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // a slot is live when its distance from the head is below the occupancy
  always_comb begin
    vld  = '0;
    tags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i]                 = {1'b0, AW'(i) - rd_q} < cnt_q;
      tags[i*TAG_W +: TAG_W] = mem_q[i][WIDTH-1 -: TAG_W];
    end
  end
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/rf_wport_arb.sv
// rf_wport_arb: shares the RF write port between WB (priority) and queued long-latency results
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [WB_RF_BUS_WD-1:0] wb_to_rf_data,
  input  logic                    lu_valid,
  output logic                    lu_ready,
  input  logic [RADDR_WD-1:0]     lu_waddr,
  input  logic [31:0]             lu_wdata,
  output logic                    rf_we,
  output logic [RADDR_WD-1:0]     rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic                    wb_hold,
  input  logic [RADDR_WD-1:0]     id_raddr1,
  input  logic [RADDR_WD-1:0]     id_raddr2,
  output logic                    pend_hit1,
  output logic                    pend_hit2
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [RADDR_WD-1:0]       wb_waddr;
  logic                      wb_act, fifo_push, fifo_pop, fifo_nempty, hit1, hit2;
  lu_ent_t                   head;
  logic [AW:0]               count;
  logic [DEPTH-1:0]          vld;
  logic [DEPTH*RADDR_WD-1:0] tags;
  logic [SW-1:0]             starve_q, starve_d;
  logic                      hold_q, hold_d;
  assign wb_waddr    = wb_to_rf_data[WADDR_MSB:WADDR_LSB];
  assign wb_act      = wb_to_rf_data[WE_BIT] & (wb_waddr != '0);
  assign fifo_nempty = count != '0;
  assign lu_ready    = count < (AW+1)'(DEPTH);
  assign fifo_push   = lu_valid & lu_ready & (lu_waddr != '0);
  assign fifo_pop    = ~wb_act & fifo_nempty;
  sync_fifo #(.WIDTH(LU_ENT_WD), .DEPTH(DEPTH), .TAG_W(RADDR_WD)) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({lu_waddr, lu_wdata}),
    .rdata (head),
    .count (count),
    .vld   (vld),
    .tags  (tags)
  );
  // combinational grant keeps WB writeback at zero added latency; quiet while reset is held
  always_comb begin
    rf_we    = resetn & (wb_act | fifo_nempty);
    rf_waddr = wb_act ? wb_waddr : head.waddr;
    rf_wdata = wb_act ? wb_to_rf_data[WDATA_MSB:WDATA_LSB] : head.wdata;
  end
  // RAW hits against every queued entry, including the one popping this cycle
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = hit1 | (vld[i] & (tags[i*RADDR_WD +: RADDR_WD] == id_raddr1));
      hit2 = hit2 | (vld[i] & (tags[i*RADDR_WD +: RADDR_WD] == id_raddr2));
    end
    pend_hit1 = hit1 & (id_raddr1 != '0);
    pend_hit2 = hit2 & (id_raddr2 != '0);
  end
  // blocked-head counter; hold follows the next counter value so it rises with saturation
  always_comb begin
    starve_d = (fifo_pop | ~fifo_nempty) ? '0 : (starve_q == SMAX) ? starve_q : starve_q + SW'(1);
    hold_d   = starve_d == SMAX;
  end
  // starvation state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end
  assign wb_hold = hold_q;
endmodule

// File: tb/tb_rf_wport_arb.sv
// tb_rf_wport_arb: scenario tasks plus a scoreboard monitor on the RF write port
module tb_rf_wport_arb;
  logic        clk = 1'b0, resetn = 1'b0;
  logic [37:0] wb_bus;
  logic        lu_valid, lu_ready, rf_we, wb_hold, pend_hit1, pend_hit2;
  logic [4:0]  lu_waddr, rf_waddr, id_raddr1, id_raddr2;
  logic [31:0] lu_wdata, rf_wdata;
  int          vec = 0, errs = 0;
  bit          mon_en = 1'b0;
  logic [36:0] sb [$];
  logic        m_wb, m_acc, m_h1, m_h2, m_ill, m_we;
  logic [36:0] m_e;

  always #5 clk = ~clk;

  rf_wport_arb #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn), .wb_to_rf_data(wb_bus),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_hold(wb_hold),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2)
  );

  // scoreboard: expected port owner, readiness and RAW hits each cycle
  always @(negedge clk) begin
    if (mon_en && resetn) begin
      m_wb  = wb_bus[37] && wb_bus[36:32] != 5'd0;
      m_acc = sb.size() < 2;
      m_h1 = 1'b0; m_h2 = 1'b0; m_ill = 1'b0;
      foreach (sb[i]) begin
        if (id_raddr1 != 5'd0 && sb[i][36:32] == id_raddr1) m_h1 = 1'b1;
        if (id_raddr2 != 5'd0 && sb[i][36:32] == id_raddr2) m_h2 = 1'b1;
        if (m_wb && sb[i][36:32] == wb_bus[36:32]) m_ill = 1'b1;
      end
      assert (!m_ill) else $error("illegal WB write to queued register x%0d", wb_bus[36:32]);
      m_we = m_wb || sb.size() > 0;
      m_e  = '0;
      if (m_wb) m_e = wb_bus[36:0];
      else if (sb.size() > 0) m_e = sb.pop_front();
      vec++;
      if (lu_ready !== m_acc) begin errs++; $display("FAIL sb_lu_ready t=%0t got %b exp %b", $time, lu_ready, m_acc); end
      vec++;
      if ({pend_hit1, pend_hit2} !== {m_h1, m_h2}) begin errs++; $display("FAIL sb_pend t=%0t got %b%b exp %b%b", $time, pend_hit1, pend_hit2, m_h1, m_h2); end
      vec++;
      if (rf_we !== m_we || (m_we && {rf_waddr, rf_wdata} !== m_e)) begin
        errs++; $display("FAIL sb_rf t=%0t got we=%b a=%0d d=%h exp we=%b a=%0d d=%h", $time, rf_we, rf_waddr, rf_wdata, m_we, m_e[36:32], m_e[31:0]);
      end
      if (lu_valid && m_acc && lu_waddr != 5'd0) sb.push_back({lu_waddr, lu_wdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_bus = '0; lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0; id_raddr1 = '0; id_raddr2 = '0;
  endtask

  task automatic test_reset();
    idle();
    wb_bus = {1'b1, 5'd2, 32'h2222_2222};
    repeat (2) tick();
    @(negedge clk);
    vec++; if (lu_ready !== 1'b1) begin errs++; $display("FAIL rst_lu_ready got %b exp 1", lu_ready); end
    vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL rst_rf_we got %b exp 0", rf_we); end
    vec++; if (wb_hold !== 1'b0) begin errs++; $display("FAIL rst_wb_hold got %b exp 0", wb_hold); end
    vec++; if ({pend_hit1, pend_hit2} !== 2'b00) begin errs++; $display("FAIL rst_pend got %b%b exp 00", pend_hit1, pend_hit2); end
    tick();
    idle();
    resetn = 1'b1;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vec++; if (lu_ready !== 1'b1) begin errs++; $display("FAIL basic_ready got %b exp 1", lu_ready); end
    vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL basic_nobypass got %b exp 0", rf_we); end
    tick();
    idle();
    @(negedge clk);
    vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin errs++; $display("FAIL basic_drain got %b/%0d/%h exp 1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
    tick();
    @(negedge clk);
    vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL basic_empty got %b exp 0", rf_we); end
    tick();
  endtask

  task automatic test_x0();
    wb_bus = {1'b1, 5'd0, 32'h1111_1111};
    lu_valid = 1'b1; lu_waddr = 5'd3; lu_wdata = 32'h3333_3333;
    @(negedge clk);
    vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL x0_ignored got %b exp 0", rf_we); end
    tick();
    lu_valid = 1'b0;
    @(negedge clk);
    vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h3333_3333}) begin errs++; $display("FAIL x0_drain got %b/%0d/%h exp 1/3/33333333", rf_we, rf_waddr, rf_wdata); end
    tick();
    @(negedge clk);
    vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL x0_after got %b exp 0", rf_we); end
    tick();
    idle();
  endtask

  task automatic test_starve();
    wb_bus = {1'b1, 5'd1, 32'h0000_0001};
    lu_valid = 1'b1; lu_waddr = 5'd8; lu_wdata = 32'h8888_8888;
    @(negedge clk);
    vec++; if (lu_ready !== 1'b1) begin errs++; $display("FAIL st_ready_c0 got %b exp 1", lu_ready); end
    tick();
    lu_waddr = 5'd9; lu_wdata = 32'h9999_9999;
    @(negedge clk);
    vec++; if (lu_ready !== 1'b1) begin errs++; $display("FAIL st_ready_c1 got %b exp 1", lu_ready); end
    tick();
    lu_valid = 1'b0;
    @(negedge clk);
    vec++; if (lu_ready !== 1'b0) begin errs++; $display("FAIL st_full_c2 got %b exp 0", lu_ready); end
    tick();
    tick();
    @(negedge clk);
    vec++; if (wb_hold !== 1'b0) begin errs++; $display("FAIL st_hold_c4 got %b exp 0", wb_hold); end
    tick();
    @(negedge clk);
    vec++; if (wb_hold !== 1'b1) begin errs++; $display("FAIL st_hold_c5 got %b exp 1", wb_hold); end
    tick();
    wb_bus = '0;
    @(negedge clk);
    vec++; if ({rf_we, rf_waddr} !== {1'b1, 5'd8}) begin errs++; $display("FAIL st_drain8 got %b/%0d exp 1/8", rf_we, rf_waddr); end
    tick();
    @(negedge clk);
    vec++; if ({rf_we, rf_waddr} !== {1'b1, 5'd9}) begin errs++; $display("FAIL st_drain9 got %b/%0d exp 1/9", rf_we, rf_waddr); end
    vec++; if (wb_hold !== 1'b0) begin errs++; $display("FAIL st_hold_c7 got %b exp 0", wb_hold); end
    tick();
    @(negedge clk);
    vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL st_empty got %b exp 0", rf_we); end
    tick();
  endtask

  task automatic test_pend();
    wb_bus = {1'b1, 5'd1, 32'h0000_0002};
    lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h7777_7777;
    id_raddr1 = 5'd7; id_raddr2 = 5'd0;
    @(negedge clk);
    vec++; if (pend_hit1 !== 1'b0) begin errs++; $display("FAIL pend_before got %b exp 0", pend_hit1); end
    tick();
    lu_valid = 1'b0;
    @(negedge clk);
    vec++; if ({pend_hit1, pend_hit2} !== 2'b10) begin errs++; $display("FAIL pend_queued got %b%b exp 10", pend_hit1, pend_hit2); end
    tick();
    wb_bus = '0;
    @(negedge clk);
    vec++; if ({pend_hit1, rf_waddr} !== {1'b1, 5'd7}) begin errs++; $display("FAIL pend_popcycle got %b/%0d exp 1/7", pend_hit1, rf_waddr); end
    tick();
    @(negedge clk);
    vec++; if (pend_hit1 !== 1'b0) begin errs++; $display("FAIL pend_after got %b exp 0", pend_hit1); end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    wb_bus = {1'b1, 5'd1, 32'h0000_0003};
    lu_valid = 1'b1; lu_waddr = 5'd4; lu_wdata = 32'h4444_4444;
    tick();
    wb_bus = '0;
    lu_waddr = 5'd9; lu_wdata = 32'h9999_0000;
    @(negedge clk);
    vec++; if ({rf_we, rf_waddr, lu_ready} !== {1'b1, 5'd4, 1'b1}) begin errs++; $display("FAIL b2b_pop4 got %b/%0d/%b exp 1/4/1", rf_we, rf_waddr, lu_ready); end
    tick();
    lu_valid = 1'b0;
    @(negedge clk);
    vec++; if ({rf_we, rf_waddr, rf_wdata, lu_ready} !== {1'b1, 5'd9, 32'h9999_0000, 1'b1}) begin errs++; $display("FAIL b2b_pop9 got %b/%0d/%h/%b exp 1/9/99990000/1", rf_we, rf_waddr, rf_wdata, lu_ready); end
    tick();
    @(negedge clk);
    vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL b2b_empty got %b exp 0", rf_we); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      wb_bus    = wb_hold ? '0 : {1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 32'($urandom)};
      lu_valid  = 1'($urandom_range(0, 1));
      lu_waddr  = $urandom_range(0, 4) == 0 ? 5'd0 : 5'($urandom_range(16, 31));
      lu_wdata  = 32'($urandom);
      id_raddr1 = 5'($urandom_range(0, 31));
      id_raddr2 = 5'($urandom_range(16, 31));
      tick();
    end
    idle();
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    wb_bus = {1'b1, 5'd1, 32'h0000_0004};
    lu_valid = 1'b1; lu_waddr = 5'd10; lu_wdata = 32'hAAAA_0000;
    id_raddr1 = 5'd10;
    tick();
    lu_waddr = 5'd11; lu_wdata = 32'hBBBB_0000;
    tick();
    lu_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    vec++; if ({wb_hold, lu_ready} !== 2'b10) begin errs++; $display("FAIL ar_pre got hold=%b ready=%b exp 1/0", wb_hold, lu_ready); end
    #2 resetn = 1'b0;
    #1;
    vec++; if ({lu_ready, wb_hold, rf_we, pend_hit1} !== 4'b1000) begin errs++; $display("FAIL ar_during got %b exp 1000", {lu_ready, wb_hold, rf_we, pend_hit1}); end
    sb.delete();
    idle();
    id_raddr1 = 5'd10;
    repeat (2) tick();
    resetn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      vec++; if ({rf_we, pend_hit1} !== 2'b00) begin errs++; $display("FAIL ar_stale cycle %0d got we=%b hit=%b exp 0/0", n, rf_we, pend_hit1); end
      tick();
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_x0();
    test_starve();
    test_pend();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
